// File: rtl/ro_freq_counter.sv
// Gated frequency counter for an asynchronous ring-oscillator signal: counts its
// synchronised rising edges over GATE_CYCLES clocks and reports the total with a valid strobe.
module ro_freq_counter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int GATE_WIDTH  = 26,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ro_in,
  input  logic                   start,
  input  logic                   continuous,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   valid,
  output logic                   overflow,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [GATE_WIDTH-1:0]  GATE_LAST = GATE_WIDTH'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  // Two-flop synchroniser plus one history flop for edge detection.
  logic s1_q, s2_q, s3_q;
  logic rise;

  state_e                 state_q, state_d;
  logic [GATE_WIDTH-1:0]  gate_cnt_q, gate_cnt_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic                   sat_q, sat_d;
  logic [COUNT_WIDTH-1:0] count_out_q, count_out_d;
  logic                   overflow_q, overflow_d;

  // Edge count and sticky flag as they would stand after this cycle's rise.
  logic [COUNT_WIDTH-1:0] edge_inc;
  logic                   sat_inc;

  // NOTE: every flop uses <= so all registers sample pre-edge values; with = the
  // synchroniser would collapse into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= ro_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Saturating increment: the counter never wraps, it pins at all-ones instead.
  always_comb begin
    edge_inc = edge_cnt_q;
    sat_inc  = sat_q;
    if (rise) begin
      if (edge_cnt_q == COUNT_MAX) begin
        sat_inc = 1'b1;
      end else begin
        edge_inc = edge_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: every signal driven here gets a hold value first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    sat_d       = sat_q;
    count_out_d = count_out_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start || continuous) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end

      GATE: begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        edge_cnt_d = edge_inc;
        sat_d      = sat_inc;
        if (gate_cnt_q == GATE_LAST) begin
          // The final gate cycle's edge is included in the reported result.
          state_d     = DONE;
          count_out_d = edge_inc;
          overflow_d  = sat_inc;
        end
      end

      DONE: begin
        // A rise landing in this cycle is dropped: one dead cycle per window.
        if (continuous) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gate_cnt_q  <= '0;
      edge_cnt_q  <= '0;
      sat_q       <= 1'b0;
      count_out_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      sat_q       <= sat_d;
      count_out_q <= count_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign count_out = count_out_q;
  assign overflow  = overflow_q;
  assign valid     = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ro_freq_counter.sv
// Bench for ro_freq_counter: a wide (32-bit) and a narrow (4-bit) instance share all
// stimulus; a history-based edge-count model predicts every reported window.
module tb_ro_freq_counter;

  localparam int G = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ro_in = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;

  logic [31:0] count_w;
  logic        valid_w, ovf_w, busy_w;
  logic [3:0]  count_n;
  logic        valid_n, ovf_n, busy_n;

  always #5 clk = ~clk;

  ro_freq_counter #(.GATE_CYCLES(G), .GATE_WIDTH(7), .COUNT_WIDTH(32)) dut_w (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .continuous(continuous),
    .count_out(count_w), .valid(valid_w), .overflow(ovf_w), .busy(busy_w)
  );

  ro_freq_counter #(.GATE_CYCLES(G), .GATE_WIDTH(7), .COUNT_WIDTH(4)) dut_n (
    .clk(clk), .rst(rst), .ro_in(ro_in), .start(start), .continuous(continuous),
    .count_out(count_n), .valid(valid_n), .overflow(ovf_n), .busy(busy_n)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Input history as seen at each clock edge; reset edges look like a low input.
  bit hist[$];
  int edge_no = -1;
  bit rst_at_edge = 1'b0;

  initial forever begin
    @(posedge clk);
    hist.push_back(rst ? 1'b0 : ro_in);
    rst_at_edge = rst;
    edge_no++;
  end

  function automatic bit h(int n);
    if (n < 0 || n >= hist.size()) return 1'b0;
    return hist[n];
  endfunction

  // A window reported after edge d spans the G cycles after edges d-G..d-1; an input
  // rise reaches the counter two clocks after it is first sampled.
  function automatic int model_count(int d);
    int c = 0;
    for (int n = d - G; n <= d - 1; n++)
      if (h(n - 1) && !h(n - 2)) c++;
    return c;
  endfunction

  // Oscillator generator: 0 = constant level, 1 = square wave (low half first),
  // 2 = random high/low times of 2..12 clocks.
  int ro_mode = 0;
  bit ro_level = 1'b0;
  int ro_period = 10;
  int ro_ph = 0;

  initial forever begin
    @(posedge clk);
    #1;
    case (ro_mode)
      0: ro_in = ro_level;
      1: begin
        ro_in = ((ro_ph % ro_period) >= ro_period / 2);
        ro_ph++;
      end
      default: begin
        if (ro_ph <= 0) begin
          ro_in = ~ro_in;
          ro_ph = $urandom_range(2, 12);
        end
        ro_ph--;
      end
    endcase
  end

  // Monitor: outputs hold until a valid, then must match the model.
  bit          mon_on = 1'b0;
  int          n_valid = 0;
  logic [31:0] hold_w = '0;
  logic [3:0]  hold_n = '0;
  bit          hold_ovf_n = 1'b0;

  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      if (rst_at_edge) begin
        hold_w = '0;
        hold_n = '0;
        hold_ovf_n = 1'b0;
      end
      check("valid_match", valid_n, valid_w);
      check("busy_match", busy_n, busy_w);
      if (valid_w === 1'b1) begin
        int c;
        c = model_count(edge_no);
        hold_w = 32'(c);
        hold_n = (c > 15) ? 4'd15 : 4'(c);
        hold_ovf_n = (c > 15);
        n_valid++;
      end
      check("count_w", count_w, hold_w);
      check("ovf_w", ovf_w, 0);
      check("count_n", count_n, hold_n);
      check("ovf_n", ovf_n, hold_ovf_n);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(output int e0);
    start = 1'b1;
    e0 = edge_no + 1;
    tick();
    start = 1'b0;
  endtask

  // Returns the edge after which valid was seen high, or -1 on timeout.
  task automatic wait_valid(input int budget, output int e);
    e = -1;
    repeat (budget) begin
      tick();
      if (valid_w === 1'b1) begin
        e = edge_no;
        break;
      end
    end
  endtask

  task automatic set_square(input int p);
    ro_mode = 1;
    ro_period = p;
    ro_ph = 0;
  endtask

  initial begin
    int e0, e, v1, v2, v3, nv, prev, cnt;

    repeat (3) tick();
    check("rst_count", count_w, 0);
    check("rst_valid", valid_w, 0);
    check("rst_ovf", ovf_w, 0);
    check("rst_busy", busy_w, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    // Single shot, period 10. Latency counts the edge that captures valid.
    set_square(10);
    repeat (5) tick();
    pulse_start(e0);
    wait_valid(200, e);
    check("t1_latency", e + 1 - e0, G + 1);
    check("t1_count", count_w, 10);
    check("t1_ovf", ovf_w, 0);
    tick();
    check("t1_valid_pulse", valid_w, 0);
    check("t1_busy_after", busy_w, 0);
    nv = n_valid;
    repeat (150) tick();
    check("t1_no_more_valid", n_valid, nv);

    // Constant low, then constant high: no edges inside either window.
    ro_mode = 0;
    ro_level = 1'b0;
    repeat (5) tick();
    pulse_start(e0);
    wait_valid(200, e);
    check("t2_latency", e + 1 - e0, G + 1);
    check("t2_count_low", count_w, 0);
    check("t2_ovf", ovf_w, 0);
    tick();
    check("t2_valid_pulse", valid_w, 0);
    ro_level = 1'b1;
    repeat (5) tick();
    pulse_start(e0);
    wait_valid(200, e);
    check("t2_count_high", count_w, 0);

    // Saturation on the 4-bit instance, then the sticky flag clears.
    set_square(4);
    repeat (3) tick();
    pulse_start(e0);
    wait_valid(200, e);
    check("t3_count_n", count_n, 15);
    check("t3_ovf_n", ovf_n, 1);
    check("t3_count_w", count_w, 25);
    set_square(10);
    repeat (3) tick();
    pulse_start(e0);
    wait_valid(200, e);
    check("t3_count_n2", count_n, 10);
    check("t3_ovf_n2", ovf_n, 0);

    // Continuous, period 20; drop continuous halfway through the third window.
    set_square(20);
    repeat (3) tick();
    continuous = 1'b1;
    e0 = edge_no + 1;
    wait_valid(200, v1);
    check("t4_first", v1 + 1 - e0, G + 1);
    check("t4_count1", count_w, 5);
    tick();
    check("t4_busy1", busy_w, 1);
    wait_valid(200, v2);
    check("t4_period1", v2 - v1, G + 1);
    check("t4_count2", count_w, 5);
    check("t4_busy_done", busy_w, 1);
    repeat (50) tick();
    check("t4_busy2", busy_w, 1);
    continuous = 1'b0;
    wait_valid(200, v3);
    check("t4_period2", v3 - v2, G + 1);
    check("t4_count3", count_w, 5);
    tick();
    check("t4_busy_end", busy_w, 0);
    nv = n_valid;
    repeat (150) tick();
    check("t4_no_fourth", n_valid, nv);

    // Reset in the middle of a window.
    set_square(10);
    repeat (3) tick();
    pulse_start(e0);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    check("t5_count", count_w, 0);
    check("t5_ovf", ovf_w, 0);
    check("t5_valid", valid_w, 0);
    check("t5_busy", busy_w, 0);
    rst = 1'b0;
    nv = n_valid;
    repeat (150) tick();
    check("t5_no_valid", n_valid, nv);
    check("t5_idle", busy_w, 0);
    pulse_start(e0);
    wait_valid(200, e);
    check("t5_count_after", count_w, 10);

    // Continuous with start toggling randomly; the cadence must not change.
    continuous = 1'b1;
    e0 = edge_no + 1;
    prev = -1;
    cnt = 0;
    for (int i = 0; i < 400 && cnt < 3; i++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      if (valid_w === 1'b1) begin
        if (cnt == 0) check("t6_first", edge_no + 1 - e0, G + 1);
        else          check("t6_period", edge_no - prev, G + 1);
        prev = edge_no;
        cnt++;
      end
    end
    check("t6_windows", cnt, 3);
    start = 1'b0;
    continuous = 1'b0;
    repeat (20) tick();
    check("t6_idle", busy_w, 0);

    // Random oscillator timing, random gaps between single-shot windows.
    ro_mode = 2;
    ro_ph = 0;
    repeat (6) begin
      repeat ($urandom_range(1, 30)) tick();
      pulse_start(e0);
      wait_valid(200, e);
      check("t7_latency", e + 1 - e0, G + 1);
    end
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
